nco_cordic: RTL and testbench
=============================

# nco_cordic

Parametrised numerically-controlled sine/cosine generator. A binary phase accumulator with programmable frequency word, phase offset and amplitude replaces the fixed 0..359 angle-index ROM sweep. Each sample is computed by an internal iterative CORDIC rotation, one iteration per clock. Samples leave on a valid/ready handshake with backpressure, so downstream DSP blocks in the signal-generation path can stall the generator without losing phase.

## Interface
- W, default 16: amplitude width; outputs are signed W+1 bits.
- PW, default 32: phase width; 2^PW equals one full turn.
- ITER, default 16, legal range 8..24: number of CORDIC iterations.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  request a new sample; consumed only at an accept edge.
- sync  in  1  zero the phase accumulator at the next accept edge.
- freq_word  in  PW  unsigned phase increment per sample.
- phase_off  in  PW  phase offset added to the accumulator, modulo 2^PW.
- amp  in  W  unsigned output amplitude.
- cos_out  out  W+1  signed amp·cos(θ), registered.
- sin_out  out  W+1  signed amp·sin(θ), registered.
- out_valid  out  1  sample pair on cos_out/sin_out is valid.
- out_ready  in  1  downstream accepts the sample.

## Operation
- States: IDLE, ROTATE, DONE.
- Accept edge: IDLE with en=1, or DONE with out_ready=1 and en=1.
- At an accept edge:
  - base = sync ? 0 : acc; θ = base + phase_off (mod 2^PW); acc ← base + freq_word.
  - en, sync, freq_word, phase_off and amp are sampled here only.
- The accumulator never advances outside accept edges, including during IDLE and backpressure. A sync asserted off an accept edge is ignored.
- Quadrant pre-rotation uses q = θ[PW-1:PW-2], with X0 = amp·19898>>15 (Q15 CORDIC gain compensation):
  - q=0: (x,y) = (X0, 0), z = θ.
  - q=1: (x,y) = (0, X0), z = θ − 2^(PW-2).
  - q=2: (x,y) = (−X0, 0), z = θ − 2^(PW-1).
  - q=3: (x,y) = (0, −X0), z = θ − 3·2^(PW-2).
- Iteration i = 0..ITER-1, with d = sign(z):
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_i.
  - atan_i = round(atan(2^-i)·2^PW/2π), held as a 32-bit constant table shifted right by 32−PW.
- x/y datapath is W+2 bits signed with arithmetic-shift truncation; z is PW bits signed.
- Outputs saturate to ±(2^W − 1); no wrap.
- Transitions:
  - IDLE→ROTATE on accept.
  - ROTATE→DONE after the last iteration; cos_out/sin_out loaded and out_valid←1 on that edge.
  - DONE with out_ready=1 and en=1: accept, go to ROTATE, out_valid←0.
  - DONE with out_ready=1 and en=0: go to IDLE, out_valid←0.
  - DONE with out_ready=0: hold; outputs and out_valid stable.

## Timing
- Reset values: cos_out=0, sin_out=0, out_valid=0, acc=0, state IDLE.
- Reset mid-ROTATE aborts the computation; no partial sample is ever presented.
- Latency: out_valid rises ITER cycles after the accept edge.
- Throughput with en and out_ready held high: one sample per ITER+1 cycles.
- Handshake: transfer when out_valid & out_ready on a rising edge. Data must not change while out_valid=1 and out_ready=0.
- Mid-computation input changes have no effect on the sample in flight.
- Accuracy (W=16, ITER=16): |error| ≤ 4 LSB versus ideal amp·cos/sin.
- Accumulator wraps modulo 2^PW silently.

## Test plan
- Reset: hold rst_n=0 with random inputs, then release with en=0 -> cos_out=sin_out=0, out_valid=0 indefinitely.
- freq_word=2^30, amp=30000, phase_off=0, en=out_ready=1 -> samples (30000,0), (0,30000), (−30000,0), (0,−30000) repeating, ±4 LSB; out_valid pulses every 17 cycles.
- Same stimulus, but out_ready=0 for 50 cycles after the first sample -> outputs frozen and out_valid high throughout; once released, the next sample is (0,30000), confirming no phase skipped.
- freq_word=0, phase_off=2^29, amp=30000 -> every sample ≈ (21213,21213) ±4 LSB; phase_off=0xE0000000 -> ≈ (21213,−21213).
- freq_word=2^30; after three samples, assert sync for exactly the accept cycle -> next sample (30000,0), following sample (0,30000).
- amp=65535 at θ=0 -> cos_out saturates at ≤65535, never negative. Assert rst_n=0 mid-ROTATE -> out_valid stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/nco_cordic_if.sv
// Sample-request / sample-delivery bundle of the NCO: control words in, one
// sine/cosine pair out on a valid/ready handshake.
interface nco_cordic_if #(
  parameter int W  = 16,
  parameter int PW = 32
);
  logic                en;
  logic                sync;
  logic [PW-1:0]       freq_word;
  logic [PW-1:0]       phase_off;
  logic [W-1:0]        amp;
  logic signed [W:0]   cos_out;
  logic signed [W:0]   sin_out;
  logic                out_valid;
  logic                out_ready;

  // Handshake: a sample pair transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the pair is frozen.
  modport master (
    output en, sync, freq_word, phase_off, amp, out_ready,
    input  cos_out, sin_out, out_valid
  );
  modport slave (
    input  en, sync, freq_word, phase_off, amp, out_ready,
    output cos_out, sin_out, out_valid
  );
endinterface

// File: rtl/nco_cordic.sv
// Phase-accumulator NCO producing amp*cos/amp*sin through an iterative CORDIC,
// one iteration per clock, with the sample held until downstream takes it.
module nco_cordic #(
  parameter int W    = 16,
  parameter int PW   = 32,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  nco_cordic_if.slave  s_if,
  output logic [1:0]   state_o
);
  localparam int XW = W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PW-1:0] QTR  = {2'b01, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] HALF = {2'b10, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] TQTR = {2'b11, {(PW-2){1'b0}}};
  localparam logic signed [XW-1:0] SAT_MAX = {2'b00, {W{1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX;

  state_t                 state_q, state_d;
  logic [PW-1:0]          acc_q;
  logic signed [XW-1:0]   x_q, y_q;
  logic [PW-1:0]          z_q;
  logic [4:0]             iter_q;
  logic signed [W:0]      cos_q, sin_q;
  logic                   valid_q, valid_d;

  logic                   accept, last_iter;
  logic [PW-1:0]          base, theta;
  logic [W+14:0]          prod;
  logic signed [XW-1:0]   x0, x_init, y_init;
  logic [PW-1:0]          z_init;
  logic signed [XW-1:0]   x_sh, y_sh, x_n, y_n;
  logic [PW-1:0]          atan_v, z_n;

  // atan(2^-i) scaled so that 2^32 is one full turn
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  atan_lut = 32'd536870912;
      5'd1:  atan_lut = 32'd316933406;
      5'd2:  atan_lut = 32'd167458907;
      5'd3:  atan_lut = 32'd85004756;
      5'd4:  atan_lut = 32'd42667331;
      5'd5:  atan_lut = 32'd21354465;
      5'd6:  atan_lut = 32'd10679838;
      5'd7:  atan_lut = 32'd5340245;
      5'd8:  atan_lut = 32'd2670163;
      5'd9:  atan_lut = 32'd1335087;
      5'd10: atan_lut = 32'd667544;
      5'd11: atan_lut = 32'd333772;
      5'd12: atan_lut = 32'd166886;
      5'd13: atan_lut = 32'd83443;
      5'd14: atan_lut = 32'd41722;
      5'd15: atan_lut = 32'd20861;
      5'd16: atan_lut = 32'd10430;
      5'd17: atan_lut = 32'd5215;
      5'd18: atan_lut = 32'd2608;
      5'd19: atan_lut = 32'd1304;
      5'd20: atan_lut = 32'd652;
      5'd21: atan_lut = 32'd326;
      5'd22: atan_lut = 32'd163;
      5'd23: atan_lut = 32'd81;
      default: atan_lut = 32'd0;
    endcase
  endfunction

  function automatic logic signed [W:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[W:0];
    else if (v < SAT_MIN) sat = SAT_MIN[W:0];
    else                  sat = v[W:0];
  endfunction

  assign accept    = s_if.en && ((state_q == IDLE) || (state_q == DONE && s_if.out_ready));
  assign last_iter = (state_q == ROTATE) && (iter_q == 5'(ITER - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROTATE;
      ROTATE:  if (last_iter) state_d = DONE;
      DONE:    if (s_if.out_ready) state_d = s_if.en ? ROTATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    valid_d = valid_q;
    if (last_iter)                                 valid_d = 1'b1;
    else if (state_q == DONE && s_if.out_ready)    valid_d = 1'b0;
  end

  // Quadrant pre-rotation leaves the CORDIC only a 0..90 degree residual
  assign base  = s_if.sync ? '0 : acc_q;
  assign theta = base + s_if.phase_off;
  assign prod  = (W+15)'(s_if.amp) * (W+15)'(19898);
  assign x0    = XW'(prod >> 15);

  always_comb begin
    x_init = x0;
    y_init = '0;
    z_init = theta;
    case (theta[PW-1:PW-2])
      2'd1: begin x_init = '0;  y_init = x0;  z_init = theta - QTR;  end
      2'd2: begin x_init = -x0; y_init = '0;  z_init = theta - HALF; end
      2'd3: begin x_init = '0;  y_init = -x0; z_init = theta - TQTR; end
      default: ;
    endcase
  end

  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_v = PW'(atan_lut(iter_q) >> (32 - PW));

  always_comb begin
    if (!z_q[PW-1]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_v;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q  <= base + s_if.freq_word;
        x_q    <= x_init;
        y_q    <= y_init;
        z_q    <= z_init;
        iter_q <= '0;
      end else if (state_q == ROTATE) begin
        x_q    <= x_n;
        y_q    <= y_n;
        z_q    <= z_n;
        iter_q <= iter_q + 5'd1;
      end
      if (last_iter) begin
        cos_q <= sat(x_n);
        sin_q <= sat(y_n);
      end
      valid_q <= valid_d;
    end
  end

  assign s_if.cos_out   = cos_q;
  assign s_if.sin_out   = sin_q;
  assign s_if.out_valid = valid_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_nco_cordic.sv
// Directed bench for nco_cordic: quadrant sweep, backpressure, phase offsets,
// sync, saturation and reset behaviour against hand-computed samples.
module tb_nco_cordic;
  localparam int W = 16, PW = 32, ITER = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_o;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         last_cyc = 0;
  int         got_c, got_s, per;
  logic [33:0] exp_q[$];

  nco_cordic_if #(.W(W), .PW(PW)) nco_if();

  nco_cordic #(.W(W), .PW(PW), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(nco_if), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    int diff;
    n_checks++;
    diff = obs - exp_v;
    if (diff < 0) diff = -diff;
    if (diff > tol)
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
    else
      n_pass++;
  endtask

  // driver tasks
  task automatic drive(input bit e, input logic [31:0] fw, input logic [31:0] po, input int a);
    nco_if.en        = e;
    nco_if.sync      = 1'b0;
    nco_if.freq_word = fw;
    nco_if.phase_off = po;
    nco_if.amp       = W'(a);
    nco_if.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_exp(input int c, input int s);
    exp_q.push_back({17'(c), 17'(s)});
  endtask

  task automatic wait_valid(input string tag, output bit found);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (nco_if.out_valid) found = 1'b1;
    end
    if (!found) check({tag, "_timeout"}, 0, 1, 0);
    got_c = nco_if.cos_out;
    got_s = nco_if.sin_out;
  endtask

  // scoreboard: pop the expected pair and compare within 4 LSB
  task automatic take_sample(input string tag, output int period);
    bit found;
    logic [33:0] e;
    wait_valid(tag, found);
    period = cyc - last_cyc;
    last_cyc = cyc;
    if (!found) return;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 0, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_cos"}, got_c, int'($signed(e[33:17])), 4);
    check({tag, "_sin"}, got_s, int'($signed(e[16:0])), 4);
  endtask

  initial begin
    int hold_c, hold_s;
    bit found;

    // reset with random inputs, then idle with en=0
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nco_if.en        = 1'($urandom_range(0, 1));
      nco_if.sync      = 1'($urandom_range(0, 1));
      nco_if.freq_word = $urandom;
      nco_if.phase_off = $urandom;
      nco_if.amp       = W'($urandom);
      nco_if.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_hold_valid", int'(nco_if.out_valid), 0, 0);
    end
    check("rst_cos", int'(nco_if.cos_out), 0, 0);
    check("rst_sin", int'(nco_if.sin_out), 0, 0);
    nco_if.en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nco_if.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_valid", int'(nco_if.out_valid), 0, 0);
    end
    check("idle_cos", int'(nco_if.cos_out), 0, 0);
    check("idle_sin", int'(nco_if.sin_out), 0, 0);
    check("idle_state", int'(state_o), 0, 0);

    // quadrant sweep, two turns, with period check
    do_reset();
    drive(1'b1, 32'h4000_0000, 0, 30000);
    last_cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      push_exp(30000, 0);
      push_exp(0, 30000);
      push_exp(-30000, 0);
      push_exp(0, -30000);
    end
    for (int k = 0; k < 8; k++) begin
      take_sample("sweep", per);
      check("sweep_period", per, ITER + 1, 0);
    end

    // backpressure: frozen output, no phase lost
    do_reset();
    drive(1'b1, 32'h4000_0000, 0, 30000);
    push_exp(30000, 0);
    take_sample("bp_first", per);
    nco_if.out_ready = 1'b0;
    hold_c = got_c;
    hold_s = got_s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_valid", int'(nco_if.out_valid), 1, 0);
      check("bp_cos_hold", int'(nco_if.cos_out), hold_c, 0);
      check("bp_sin_hold", int'(nco_if.sin_out), hold_s, 0);
    end
    nco_if.out_ready = 1'b1;
    push_exp(0, 30000);
    take_sample("bp_next", per);

    // fixed phase offsets of 45 and 315 degrees
    do_reset();
    drive(1'b1, 0, 32'h2000_0000, 30000);
    push_exp(21213, 21213);
    push_exp(21213, 21213);
    take_sample("off45", per);
    take_sample("off45", per);
    nco_if.phase_off = 32'hE000_0000;
    push_exp(21213, -21213);
    push_exp(21213, -21213);
    take_sample("off315", per);
    take_sample("off315", per);

    // sync on one accept edge restarts the sweep from zero phase
    do_reset();
    drive(1'b1, 32'h4000_0000, 0, 30000);
    push_exp(30000, 0);
    push_exp(0, 30000);
    push_exp(-30000, 0);
    for (int k = 0; k < 3; k++) take_sample("pre_sync", per);
    nco_if.sync = 1'b1;
    @(negedge clk);
    nco_if.sync = 1'b0;
    push_exp(30000, 0);
    push_exp(0, 30000);
    take_sample("sync_0", per);
    take_sample("sync_90", per);

    // full-scale amplitude at zero phase
    do_reset();
    drive(1'b1, 0, 0, 65535);
    wait_valid("sat", found);
    check("sat_le_max", int'(got_c <= 65535), 1, 0);
    check("sat_nonneg", int'(got_c >= 0), 1, 0);
    check("sat_sin", got_s, 0, 4);

    // reset in the middle of a rotation
    repeat (5) @(negedge clk);
    check("mid_state_rotate", int'(state_o), 1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(nco_if.out_valid), 0, 0);
    check("mid_rst_cos", int'(nco_if.cos_out), 0, 0);
    check("mid_rst_sin", int'(nco_if.sin_out), 0, 0);
    nco_if.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_rst_valid", int'(nco_if.out_valid), 0, 0);
    end
    check("post_rst_cos", int'(nco_if.cos_out), 0, 0);
    check("post_rst_state", int'(state_o), 0, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
